// File: rtl/gray_ctrl_pkg.sv
// Shared op-codes, state encoding and default width for the Gray-code
// counter sequencer.
package gray_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] OP_RUN_N    = 2'b00;
  localparam logic [1:0] OP_RUN_FREE = 2'b01;
  localparam logic [1:0] OP_STOP     = 2'b10;
  localparam logic [1:0] OP_LOAD     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN_N    = 2'd1,
    ST_RUN_FREE = 2'd2
  } state_t;

endpackage

// File: rtl/bin2gray.sv
// Combinational binary-to-Gray converter: g = b ^ (b >> 1).
module bin2gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] g
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
      assign g[gi] = b[gi] ^ b[gi+1];
    end
  endgenerate

  assign g[WIDTH-1] = b[WIDTH-1];

endmodule

// File: rtl/gray_count_ctrl.sv
// Command-driven Gray-code counter sequencer: binary count register whose
// Gray encoding is streamed over a valid/ready interface.
module gray_count_ctrl
  import gray_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic [WIDTH-1:0] g_out,
  output logic             g_valid,
  input  logic             g_ready,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             cmd_err
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic             done_reg, done_next;
  logic             wrap_reg, wrap_next;
  logic             err_reg, err_next;
  logic             xfer;
  logic             cmd_fire;

  assign cmd_ready = 1'b1;
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign g_valid   = (state_reg != ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign xfer      = g_valid & g_ready;
  assign done      = done_reg;
  assign wrap      = wrap_reg;
  assign cmd_err   = err_reg;

  // g_out follows the registered count, so it can only move after a transfer or LOAD.
  bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
    .b (cnt_reg),
    .g (g_out)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rem_next   = rem_reg;
    done_next  = 1'b0;
    wrap_next  = 1'b0;
    err_next   = 1'b0;

    if (state_reg == ST_IDLE) begin
      if (cmd_fire) begin
        case (cmd_op)
          OP_LOAD: cnt_next = cmd_arg;
          OP_RUN_N: begin
            if (cmd_arg != '0) begin
              rem_next   = cmd_arg;
              state_next = ST_RUN_N;
            end else begin
              done_next = 1'b1;
            end
          end
          OP_RUN_FREE: state_next = ST_RUN_FREE;
          default: ;
        endcase
      end
    end else begin
      if (xfer) begin
        cnt_next  = cnt_reg + 1'b1;
        wrap_next = &cnt_reg;
        if (state_reg == ST_RUN_N) begin
          rem_next = rem_reg - 1'b1;
          if (rem_reg == WIDTH'(1)) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      // STOP and a final transfer both land in IDLE; done above is kept regardless.
      if (cmd_fire) begin
        if (cmd_op == OP_STOP) state_next = ST_IDLE;
        else                   err_next   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      rem_reg   <= '0;
      done_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rem_reg   <= rem_next;
      done_reg  <= done_next;
      wrap_reg  <= wrap_next;
      err_reg   <= err_next;
    end
  end

endmodule

// File: tb/tb_gray_count_ctrl.sv
// Scoreboard bench for gray_count_ctrl: directed scenarios followed by random
// commands and backpressure, checked against a behavioural model.
module tb_gray_count_ctrl;

  localparam int W    = 4;
  localparam int MOD  = 1 << W;
  localparam int MAXV = MOD - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_arg = '0;
  logic [W-1:0] g_out;
  logic         g_valid;
  logic         g_ready = 1'b0;
  logic         busy;
  logic         done;
  logic         wrap;
  logic         cmd_err;

  gray_count_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .g_out     (g_out),
    .g_valid   (g_valid),
    .g_ready   (g_ready),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    bit d;
    bit w;
    bit e;
    int g;
  } exp_t;

  exp_t st_q[$];
  int   xq[$];
  int   tests  = 0;
  int   failed = 0;
  int   n_xfer = 0;

  // model: mode 0 = idle, 1 = counted run, 2 = free run
  int m_mode = 0;
  int m_cnt  = 0;
  int m_rem  = 0;

  function automatic int gray(input int c);
    return (c ^ (c >> 1)) & MAXV;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit cv, input logic [1:0] op,
                      input int arg, input bit gr);
    exp_t e;
    bit   running;
    bit   xf;
    int   new_mode;
    @(negedge clk);
    rst       = r;
    cmd_valid = cv;
    cmd_op    = op;
    cmd_arg   = arg[W-1:0];
    g_ready   = gr;
    arg       = arg & MAXV;
    e         = '{0, 0, 0, 0, 0};
    if (r) begin
      m_mode = 0; m_cnt = 0; m_rem = 0;
      st_q.push_back(e);
      return;
    end
    running  = (m_mode != 0);
    xf       = running && gr;
    new_mode = m_mode;
    if (xf) begin
      xq.push_back(gray(m_cnt));
      e.w   = (m_cnt == MAXV);
      m_cnt = (m_cnt + 1) % MOD;
      if (m_mode == 1) begin
        m_rem--;
        if (m_rem == 0) begin
          new_mode = 0;
          e.d      = 1;
        end
      end
    end
    if (cv) begin
      if (!running) begin
        case (op)
          2'b11: m_cnt = arg;
          2'b00: if (arg > 0) begin m_rem = arg; new_mode = 1; end else e.d = 1;
          2'b01: new_mode = 2;
          default: ;
        endcase
      end else if (op == 2'b10) begin
        new_mode = 0;
      end else begin
        e.e = 1;
      end
    end
    m_mode = new_mode;
    e.v    = (m_mode != 0);
    e.g    = gray(m_cnt);
    st_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit gr);
    for (int i = 0; i < n; i++) step(0, 0, 2'b00, 0, gr);
  endtask

  // Monitor: per-cycle status check plus transfer-code check.
  initial begin
    exp_t e;
    int   x;
    forever begin
      @(negedge clk);
      #2;
      if (st_q.size() >= 2) begin
        e = st_q.pop_front();
        chk("g_valid", int'(g_valid), int'(e.v));
        chk("busy", int'(busy), int'(e.v));
        chk("done", int'(done), int'(e.d));
        chk("wrap", int'(wrap), int'(e.w));
        chk("cmd_err", int'(cmd_err), int'(e.e));
        chk("g_out", int'(g_out), e.g);
        chk("cmd_ready", int'(cmd_ready), 1);
      end
      if (g_valid === 1'b1 && g_ready === 1'b1 && rst === 1'b0) begin
        n_xfer++;
        if (xq.size() == 0) begin
          chk("xfer_unexpected", int'(g_out), -1);
        end else begin
          x = xq.pop_front();
          chk("xfer_code", int'(g_out), x);
        end
      end
    end
  end

  initial begin
    int op;
    // reset
    step(1, 0, 2'b00, 0, 0);
    step(1, 0, 2'b00, 0, 0);
    idle(2, 1);
    // LOAD 5, RUN_N 3 -> 0111 0101 0100, done, g_out 1100
    step(0, 1, 2'b11, 5, 1);
    step(0, 1, 2'b00, 3, 1);
    idle(5, 1);
    // LOAD 14, RUN_FREE across the wrap, then STOP
    step(0, 1, 2'b11, 14, 1);
    step(0, 1, 2'b01, 0, 1);
    idle(4, 1);
    step(0, 1, 2'b10, 0, 1);
    idle(2, 1);
    // RUN_N 2 from 0 with stalls
    step(0, 1, 2'b11, 0, 0);
    step(0, 1, 2'b00, 2, 0);
    step(0, 0, 2'b00, 0, 0);
    step(0, 0, 2'b00, 0, 0);
    step(0, 0, 2'b00, 0, 1);
    step(0, 0, 2'b00, 0, 0);
    step(0, 0, 2'b00, 0, 1);
    idle(3, 1);
    // RUN_N 0, then LOAD dropped during RUN_FREE
    step(0, 1, 2'b00, 0, 1);
    idle(2, 1);
    step(0, 1, 2'b01, 0, 0);
    step(0, 1, 2'b11, 7, 0);
    step(0, 1, 2'b10, 0, 0);
    idle(2, 0);
    // RUN_N 4 stopped on 2nd transfer; then stopped on 4th transfer
    step(0, 1, 2'b00, 4, 1);
    step(0, 0, 2'b00, 0, 1);
    step(0, 1, 2'b10, 0, 1);
    idle(2, 1);
    step(0, 1, 2'b00, 4, 1);
    idle(3, 1);
    step(0, 1, 2'b10, 0, 1);
    idle(2, 1);
    // reset mid RUN_FREE at cnt 9
    step(0, 1, 2'b11, 9, 0);
    step(0, 1, 2'b01, 0, 0);
    step(0, 0, 2'b00, 0, 0);
    step(1, 0, 2'b00, 0, 1);
    idle(3, 1);
    // random phase
    for (int i = 0; i < 2000; i++) begin
      op = int'($urandom_range(0, 3));
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 4) == 0),
           op[1:0], int'($urandom_range(0, MAXV)), ($urandom_range(0, 9) < 7));
    end
    idle(3, 0);
    chk("xfer_queue_drained", xq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/gray_count_ctrl.md
Name: gray_count_ctrl

Overview:
Command-driven sequencer for a WIDTH-bit Gray-code counter. It holds a binary count register and emits its Gray encoding over a valid/ready stream. A host issues LOAD, RUN_N, RUN_FREE and STOP commands. The block sits between the control host and any downstream consumer of Gray codes, e.g. a pointer-sync or encoder stage.

Parameters:
WIDTH, 4, counter and Gray code width in bits (minimum 2).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready.
cmd_op  input  2  00=RUN_N, 01=RUN_FREE, 10=STOP, 11=LOAD.
cmd_arg  input  WIDTH  RUN_N: number of codes to emit. LOAD: binary start value. Ignored for other ops.
g_out  output  WIDTH  Gray code of current count, gray(cnt)=cnt^(cnt>>1).
g_valid  output  1  g_out is offered downstream.
g_ready  input  1  downstream accepts g_out.
busy  output  1  state != IDLE.
done  output  1  one-cycle pulse when a RUN_N completes.
wrap  output  1  one-cycle pulse when a transfer occurs with cnt all-ones.
cmd_err  output  1  one-cycle pulse when a command is dropped.

Behaviour:
- Clock/reset: one clock, clk. rst is synchronous and active-high.
- On rst: state=IDLE, cnt=0, remaining=0, g_out=0, g_valid=0, busy=0, done=0, wrap=0, cmd_err=0. Reset mid-run aborts immediately with no done pulse.
- cmd_ready is constantly 1 out of reset. Commands are never stalled; unsupported ones are dropped and flagged.
- States:
  - IDLE: g_valid=0.
  - RUN_N: g_valid=1, remaining counts down.
  - RUN_FREE: g_valid=1, unbounded.
- Commands in IDLE:
  - LOAD: cnt<=cmd_arg. g_out reflects the new value the next cycle.
  - RUN_N with arg>0: remaining<=arg, go RUN_N.
  - RUN_N with arg=0: stay IDLE, pulse done next cycle.
  - RUN_FREE: go RUN_FREE.
  - STOP: no-op, no error.
- Commands in RUN_N/RUN_FREE:
  - STOP: go IDLE next cycle.
  - Any other op: dropped, cmd_err pulses next cycle, state unchanged.
- Latency: a command accepted in cycle t is visible in state, g_valid and busy at t+1. The first code emitted is gray(cnt) at run start.
- Transfer = g_valid&&g_ready. On each transfer: cnt<=cnt+1, modulo 2^WIDTH with natural wrap. wrap pulses the next cycle if cnt was all-ones.
- Backpressure: while g_valid&&!g_ready, g_out and cnt hold stable. g_out never changes without a transfer while g_valid=1.
- RUN_N: each transfer decrements remaining. The transfer with remaining=1 is the last one; next cycle: state=IDLE, g_valid=0, done=1 for one cycle.
- STOP coincident with a transfer: the transfer completes (cnt increments) and the block goes IDLE.
  - If it was the final RUN_N transfer, done still pulses, because completion has priority.
  - Otherwise no done pulse.
- g_out is registered: it updates the cycle after cnt changes via registered bin2gray, or equivalently is driven from registered cnt. The emitted value must always equal gray(cnt).
- done, wrap and cmd_err are registered single-cycle pulses and never stretch.

Decomposition:
- Package gray_ctrl_pkg:
  - op-code localparams OP_RUN_N, OP_RUN_FREE, OP_STOP, OP_LOAD.
  - state encoding ST_IDLE, ST_RUN_N, ST_RUN_FREE.
  - default WIDTH.
- Sub-module bin2gray: combinational, WIDTH-parameterised, g = b ^ (b >> 1). It is instantiated once; the controller owns all state.

Test Plan:
- LOAD 5, then RUN_N 3 with g_ready=1 -> g_out sequence 0111, 0101, 0100 over three cycles with g_valid=1; done pulse on the next cycle; g_out=1100; busy=0.
- LOAD 14, RUN_FREE, g_ready=1 -> g_out 1001, 1000, 0000, 0001. wrap pulses exactly once, in the cycle after the 1000 transfer. Then STOP -> g_valid=0 next cycle.
- RUN_N 2 from cnt=0 with g_ready toggling 0,0,1,0,1 -> g_out holds 0000 through the stalls, then 0001. Exactly 2 transfers, then done. No code is skipped or repeated.
- RUN_N 0 in IDLE -> no g_valid, done pulses one cycle later. LOAD issued during RUN_FREE -> cmd_err pulse, cnt unaffected.
- RUN_N 4 with STOP on the 2nd transfer cycle -> cnt advances by 2, IDLE, no done. Separately, STOP on the 4th transfer -> done pulses.
- rst asserted for one cycle mid-RUN_FREE at cnt=9 -> next cycle all outputs 0, cnt=0, state IDLE, no done or wrap pulse.
